// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller and system-bus arbiter: a CPU write to DMA_REG_ADDR copies XFER_LEN bytes
// from {src,8'h00} into OAM, one byte per ce. Optional macro: OAM_DMA_ECHO_REMAP_EN.
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter int unsigned XFER_LEN     = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_d_out,
   output logic [7:0]  cpu_d_in,
   output logic [15:0] bus_addr,
   output logic        bus_write,
   input  logic [7:0]  bus_rd_data,
   output logic [7:0]  oam_addr,
   output logic        oam_we,
   output logic [7:0]  oam_wdata,
   output logic        dma_busy
);

   typedef enum logic [1:0] {StIdle, StStart, StXfer} state_e;

   localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

   state_e     state_q;
   logic [7:0] src_q;
   logic [7:0] idx_q;
   logic       busy_q;

   logic       reg_sel;
   logic       reg_wr;
   logic       io_page;
   logic [7:0] src_eff;

   assign reg_sel = (cpu_addr == DMA_REG_ADDR);
   assign reg_wr  = ce & cpu_write & reg_sel;
   assign io_page = (cpu_addr[15:8] == 8'hFF);

`ifdef OAM_DMA_ECHO_REMAP_EN
   // Echo RAM (E0-FF) folds onto WRAM (C0-DF) by clearing bit 5.
   assign src_eff = (src_q >= 8'hE0) ? {src_q[7:6], 1'b0, src_q[4:0]} : src_q;
`else
   assign src_eff = src_q;
`endif

   // A register write wins over every state so a busy transfer restarts cleanly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         src_q   <= 8'h00;
         idx_q   <= 8'h00;
         busy_q  <= 1'b0;
      end else if (ce) begin
         if (reg_wr) begin
            src_q   <= cpu_d_out;
            idx_q   <= 8'h00;
            state_q <= StStart;
            busy_q  <= 1'b1;
         end else begin
            unique case (state_q)
               StStart: begin
                  state_q <= StXfer;
               end
               StXfer: begin
                  if (idx_q == LastIdx) begin
                     state_q <= StIdle;
                     idx_q   <= 8'h00;
                     busy_q  <= 1'b0;
                  end else begin
                     idx_q <= idx_q + 8'd1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   always_comb begin
      bus_addr  = cpu_addr;
      bus_write = cpu_write;
      cpu_d_in  = bus_rd_data;
      unique case (state_q)
         StStart: begin
            if (!io_page) begin
               bus_write = 1'b0;
               cpu_d_in  = 8'hFF;
            end
         end
         StXfer: begin
            // DMA owns the bus, so even IO reads see open-bus.
            bus_addr  = {src_eff, idx_q};
            bus_write = 1'b0;
            cpu_d_in  = 8'hFF;
         end
         default: begin
         end
      endcase
      if (reg_sel) begin
         cpu_d_in = src_q;
      end
   end

   assign oam_we    = (state_q == StXfer) & ce;
   assign oam_addr  = idx_q;
   assign oam_wdata = oam_we ? bus_rd_data : 8'h00;
   assign dma_busy  = busy_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized scoreboard bench for oam_dma_ctrl: expected OAM writes are queued at the source
// write, and a negedge monitor pops and compares each oam_we pulse.
module tb_oam_dma_ctrl;

   localparam logic [15:0] RegAddr = 16'hFF46;
   localparam int XferLen = 160;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [15:0] cpu_addr;
   logic        cpu_write;
   logic [7:0]  cpu_d_out;
   logic [7:0]  cpu_d_in;
   logic [15:0] bus_addr;
   logic        bus_write;
   logic [7:0]  bus_rd_data;
   logic [7:0]  oam_addr;
   logic        oam_we;
   logic [7:0]  oam_wdata;
   logic        dma_busy;

   oam_dma_ctrl #(
      .DMA_REG_ADDR(RegAddr),
      .XFER_LEN    (XferLen)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .cpu_addr   (cpu_addr),
      .cpu_write  (cpu_write),
      .cpu_d_out  (cpu_d_out),
      .cpu_d_in   (cpu_d_in),
      .bus_addr   (bus_addr),
      .bus_write  (bus_write),
      .bus_rd_data(bus_rd_data),
      .oam_addr   (oam_addr),
      .oam_we     (oam_we),
      .oam_wdata  (oam_wdata),
      .dma_busy   (dma_busy)
   );

   always #5 clk = ~clk;

   // Bus model: every location reads as its low address byte XOR 5A.
   assign bus_rd_data = bus_addr[7:0] ^ 8'h5A;

   typedef struct packed {
      logic [7:0]  addr;
      logic [7:0]  data;
      logic [15:0] baddr;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   pulses = 0;
   int   busy_cycles = 0;
   logic last_we;
   logic last_busy;

   // Reference model: source byte, pending setup cycle, bytes still to copy.
   logic [7:0] m_src;
   bit         m_start;
   int         m_left;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] eff_hi(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_REMAP_EN
      if (s >= 8'hE0) return s - 8'h20;
`endif
      return s;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && oam_we) begin
         pulses++;
         if (exp_q.size() == 0) begin
            chk("oam_we_unexpected", {31'd0, oam_we}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("oam_addr", {24'd0, oam_addr}, {24'd0, e.addr});
            chk("oam_wdata", {24'd0, oam_wdata}, {24'd0, e.data});
            chk("dma_bus_addr", {16'd0, bus_addr}, {16'd0, e.baddr});
         end
      end
      if (!rst && dma_busy && bus_addr[15:8] != 8'hFF)
         chk("fenced_bus_write", {31'd0, bus_write}, 32'd0);
   end

   // One M-cycle: ce high for a single clk, then gap idle clks. Called at posedge+1.
   task automatic mcyc(input logic [15:0] a, input logic w, input logic [7:0] d, input int gap);
      logic [7:0] exp_din;
      bit         idle;
      bit         start;
      exp_t       e;
      cpu_addr  = a;
      cpu_write = w;
      cpu_d_out = d;
      ce        = 1'b1;
      idle  = !m_start && m_left == 0;
      start = m_start;
      if (a == RegAddr) exp_din = m_src;
      else if (idle || (start && a[15:8] == 8'hFF)) exp_din = a[7:0] ^ 8'h5A;
      else exp_din = 8'hFF;
      @(negedge clk);
      last_we   = oam_we;
      last_busy = dma_busy;
      if (dma_busy) busy_cycles++;
      chk("cpu_d_in", {24'd0, cpu_d_in}, {24'd0, exp_din});
      chk("dma_busy", {31'd0, dma_busy}, {31'd0, !idle});
      if (idle || start) chk("bus_addr_pass", {16'd0, bus_addr}, {16'd0, a});
      if (idle) chk("bus_write_pass", {31'd0, bus_write}, {31'd0, w});
      else if (start) chk("bus_write_start", {31'd0, bus_write}, {31'd0, w && a[15:8] == 8'hFF});
      else chk("bus_write_xfer", {31'd0, bus_write}, 32'd0);
      @(posedge clk);
      #1;
      if (w && a == RegAddr) begin
         m_src   = d;
         m_start = 1'b1;
         m_left  = XferLen;
         exp_q.delete();
         for (int i = 0; i < XferLen; i++) begin
            e.addr  = 8'(i);
            e.data  = 8'(i) ^ 8'h5A;
            e.baddr = {eff_hi(d), 8'(i)};
            exp_q.push_back(e);
         end
      end else if (m_start) begin
         m_start = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
      end
      ce        = 1'b0;
      cpu_write = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [15:0] rnd_addr();
      logic [15:0] a;
      case ($urandom_range(0, 5))
         0: a = 16'($urandom);
         1: a = 16'hFE00 + 16'($urandom_range(0, 159));
         2: a = {8'hFF, 8'($urandom)};
         3: a = 16'h0150;
         4: a = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
         default: a = RegAddr;
      endcase
      return a;
   endfunction

   task automatic rnd_cyc();
      logic [15:0] a;
      logic        w;
      a = rnd_addr();
      w = (a != RegAddr) && ($urandom_range(0, 2) == 0);
      mcyc(a, w, 8'($urandom), int'($urandom_range(0, 3)));
   endtask

   task automatic run_to_done();
      int n = 0;
      while ((m_start || m_left > 0) && n < 1000) begin
         rnd_cyc();
         n++;
      end
      chk("xfer_finished", {31'd0, dma_busy}, 32'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      rst = 1'b0; ce = 1'b0; cpu_addr = 16'h1234; cpu_write = 1'b1; cpu_d_out = 8'h00;
      m_src = 8'h00; m_start = 1'b0; m_left = 0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 ce = 1'b1;
      @(negedge clk);
      chk("rst_busy", {31'd0, dma_busy}, 32'd0);
      chk("rst_oam_we", {31'd0, oam_we}, 32'd0);
      chk("rst_oam_addr", {24'd0, oam_addr}, 32'd0);
      chk("rst_oam_wdata", {24'd0, oam_wdata}, 32'd0);
      chk("rst_bus_addr", {16'd0, bus_addr}, 32'h1234);
      chk("rst_bus_write", {31'd0, bus_write}, 32'd1);
      cpu_addr = RegAddr; cpu_write = 1'b0;
      #1 chk("rst_ff46_read", {24'd0, cpu_d_in}, 32'd0);
      @(posedge clk);
      #1 ce = 1'b0; rst = 1'b0;

      // Basic transfer from C1 with explicit fencing probes.
      busy_cycles = 0;
      base = pulses;
      mcyc(RegAddr, 1'b1, 8'hC1, 1);
      mcyc(16'h0000, 1'b0, 8'h00, 2);
      chk("start_no_we", {31'd0, last_we}, 32'd0);
      chk("start_busy", {31'd0, last_busy}, 32'd1);
      mcyc(16'h0150, 1'b0, 8'h00, 0);
      mcyc(16'hFE00, 1'b0, 8'h00, 1);
      mcyc(16'h8000, 1'b1, 8'h77, 0);
      mcyc(RegAddr, 1'b0, 8'h00, 3);
      run_to_done();
      chk("busy_mcycles", busy_cycles, 32'd161);
      chk("pulses_c1", pulses - base, 32'd160);
      chk("queue_empty_c1", exp_q.size(), 32'd0);

      // Restart at idx 50, then a ce stall mid-transfer.
      mcyc(RegAddr, 1'b1, 8'hC0, 0);
      base = pulses;
      n = 0;
      while (pulses - base < 50 && n < 500) begin
         rnd_cyc();
         n++;
      end
      chk("restart_at_50", pulses - base, 32'd50);
      mcyc(RegAddr, 1'b1, 8'hD0, 1);
      base = pulses;
      mcyc(16'hC000, 1'b0, 8'h00, 0);
      chk("restart_start_no_we", {31'd0, last_we}, 32'd0);
      chk("restart_start_busy", {31'd0, last_busy}, 32'd1);
      repeat (20) rnd_cyc();
      repeat (10) begin
         @(negedge clk);
         chk("hold_no_we", {31'd0, oam_we}, 32'd0);
         chk("hold_oam_addr", {24'd0, oam_addr}, {24'd0, 8'(XferLen - m_left)});
         @(posedge clk);
         #1;
      end
      run_to_done();
      chk("pulses_d0", pulses - base, 32'd160);
      chk("queue_empty_d0", exp_q.size(), 32'd0);

      // Echo-region source; readback must return the written value.
      mcyc(RegAddr, 1'b1, 8'hE2, 0);
      mcyc(RegAddr, 1'b0, 8'h00, 1);
      run_to_done();

      // A couple of fully random sources.
      repeat (2) begin
         mcyc(RegAddr, 1'b1, 8'($urandom), int'($urandom_range(0, 2)));
         run_to_done();
      end

      // Reset mid-transfer at idx 37.
      mcyc(RegAddr, 1'b1, 8'($urandom), 0);
      base = pulses;
      n = 0;
      while (pulses - base < 37 && n < 500) begin
         rnd_cyc();
         n++;
      end
      chk("reset_at_37", pulses - base, 32'd37);
      rst = 1'b1; ce = 1'b1; cpu_addr = RegAddr; cpu_write = 1'b0;
      exp_q.delete();
      m_src = 8'h00; m_start = 1'b0; m_left = 0;
      @(negedge clk);
      chk("midrst_no_we", {31'd0, oam_we}, 32'd0);
      chk("midrst_busy", {31'd0, dma_busy}, 32'd0);
      chk("midrst_ff46", {24'd0, cpu_d_in}, 32'd0);
      @(posedge clk);
      #1 ce = 1'b0; rst = 1'b0;
      base = pulses;
      repeat (8) rnd_cyc();
      mcyc(RegAddr, 1'b0, 8'h00, 0);
      chk("post_rst_pulses", pulses - base, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- OAM DMA controller and bus arbiter for the DMG core.
- On a CPU write to FF46, it copies XFER_LEN bytes from {src,8'h00} upward into OAM (FE00+), one byte per CPU M-cycle (cpu_ce).
- While busy, it owns the system address bus and fences CPU access to everything outside FF00-FFFF.
- Sits between the sm83 bus outputs and the address decode/bus mux in dmg_main.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source register.
- XFER_LEN, 160, bytes per transfer; must be <= 256.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- ce  input  1  M-cycle enable (cpu_ce); all state advances only when ce=1
- cpu_addr  input  16  CPU address
- cpu_write  input  1  CPU write strobe
- cpu_d_out  input  8  CPU write data
- cpu_d_in  output  8  data returned to CPU (gated bus data)
- bus_addr  output  16  arbitrated address to the decode/mux
- bus_write  output  1  arbitrated write strobe to the decode/mux
- bus_rd_data  input  8  read data from the decode/mux for bus_addr
- oam_addr  output  8  OAM write index
- oam_we  output  1  OAM write strobe, one clk wide
- oam_wdata  output  8  OAM write data
- dma_busy  output  1  high in START or XFER

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, src=8'h00, idx=0.
  - dma_busy=0, oam_we=0, oam_addr=0, oam_wdata=0.
  - bus_addr=cpu_addr, bus_write=cpu_write.
- Register write: a clk edge with ce=1, cpu_write=1 and cpu_addr==DMA_REG_ADDR latches src=cpu_d_out, sets idx=0 and state=START. This applies from any state, so a write during START or XFER restarts the transfer.
- Register read: cpu_addr==DMA_REG_ADDR returns src on cpu_d_in in every state.
- States:
  - IDLE: bus passes through. bus_addr=cpu_addr, bus_write=cpu_write, cpu_d_in=bus_rd_data (except FF46 read).
  - START: one M-cycle setup delay. dma_busy=1. The bus passes through with CPU fencing applied. The next ce moves state to XFER.
  - XFER: bus_addr={src,idx}, bus_write=0. During the clk cycle where ce=1: oam_we=1, oam_addr=idx, oam_wdata=bus_rd_data. At that edge idx increments. If idx==XFER_LEN-1, state goes to IDLE and idx to 0.
- Latency: a write to FF46 at M-cycle N gives OAM byte 0 written at M-cycle N+2 and the last byte at N+1+XFER_LEN. dma_busy falls at the edge after the last write.
- CPU fencing while dma_busy=1:
  - Reads outside FF00-FFFF return 8'hFF; this includes OAM FE00-FE9F.
  - Writes outside FF00-FFFF are dropped. In XFER, bus_write is owned by DMA and stays 0. In START, bus_write is forced 0 for fenced addresses.
  - FF00-FFFF passes through. In XFER the CPU sees only FF46 readback plus 8'hFF for other IO reads, and IO writes other than FF46 are dropped, because the bus is owned by DMA.
- oam_we is combinational (state==XFER && ce), so it pulses exactly one clk per M-cycle. oam_addr and oam_wdata are valid in the same cycle.
- ce=0 cycles hold all state; a transfer never advances without ce.
- Source above DF (without the optional feature) is passed unmodified to bus_addr.
- Reset asserted mid-transfer aborts immediately: no further oam_we, and src clears to 0.

Optional Feature:
- Macro: OAM_DMA_ECHO_REMAP_EN.
- Defined: the effective source high byte is src with bit 5 cleared when src>=8'hE0 (E0-FF maps to C0-DF, i.e. echo RAM to WRAM) in bus_addr generation. FF46 readback still returns the written src.
- Undefined: bus_addr uses src unmodified.

Test Plan:
- Reset with rst pulsed mid-XFER at idx=37 -> oam_we stays 0 from the reset edge onward, dma_busy=0, FF46 reads 8'h00.
- CPU writes 8'hC1 to FF46 with the bus model returning low byte XOR 8'h5A -> one START M-cycle, then 160 oam_we pulses at addresses 0..159 with data (i^8'h5A), bus_addr C100..C19F, and dma_busy high for exactly 161 M-cycles.
- Fencing: during XFER, CPU reads 0x0150 and FE00 -> 8'hFF, and a CPU write to 0x8000 -> bus_write never 1. A CPU read of FF46 during XFER returns 8'hC1.
- Restart: write 8'hC0 to FF46, then write 8'hD0 at idx=50 -> one START M-cycle, idx resets to 0, and the next 160 writes source from D000-D09F.
- ce gating: hold ce=0 for 10 clk mid-XFER -> idx and oam_addr unchanged and no oam_we. Transfer completes with exactly 160 pulses total.
- Remap: with OAM_DMA_ECHO_REMAP_EN defined, writing 8'hE2 gives bus_addr C200..C29F, and FF46 reads 8'hE2. Without the macro, bus_addr is E200..E29F.
